// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory and buffers {pc, instr} pairs in a small queue toward decode.
// A redirect flushes the queue and squashes any fetch still in flight.
module if_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           FQ_DEPTH   = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_instr
);

    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FQ_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDiscard
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   inflight_pc_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH-1:0]   fq_pc_q    [FQ_DEPTH];
    logic [DATA_WIDTH-1:0]   fq_instr_q [FQ_DEPTH];

    logic grant;
    logic push;
    logic pop;

    // Handshake decode; redirect cancels request, push and pop in the same cycle.
    // Gating with rst_n keeps outputs quiet even before the first reset edge.
    always_comb begin
        imem_req  = rst_n && (state_q == StIdle) && (count_q < DEPTH_CNT) && !redirect_valid;
        imem_addr = imem_req ? pc_q : '0;
        grant     = imem_req && imem_gnt;
        push      = (state_q == StWait) && imem_rvalid && !redirect_valid;
        if_valid  = rst_n && (count_q != '0);
        pop       = if_valid && if_ready && !redirect_valid;
        if_pc     = if_valid ? fq_pc_q[rd_ptr_q]    : '0;
        if_instr  = if_valid ? fq_instr_q[rd_ptr_q] : '0;
    end

    // Fetch FSM next state: a response always closes the outstanding fetch,
    // a redirect without one turns WAIT into DISCARD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (grant) state_d = StWait;
            end
            StWait: begin
                if (imem_rvalid)         state_d = StIdle;
                else if (redirect_valid) state_d = StDiscard;
            end
            StDiscard: begin
                if (imem_rvalid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next PC and queue occupancy.
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            count_d = '0;
        end else begin
            if (grant) pc_d = pc_q + ADDR_WIDTH'(4);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_ADDR;
            inflight_pc_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            if (grant) inflight_pc_q <= pc_q;
            if (redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Queue storage; contents are only observed through count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fq_pc_q[wr_ptr_q]    <= inflight_pc_q;
            fq_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that owns the program counter and consumes the next-PC selection (sequential PC+4 or jump target). It issues word fetches to instruction memory over a request/grant plus response-valid interface, one outstanding at a time. Fetched {pc, instr} pairs are buffered in a small FIFO toward decode. A redirect flushes the FIFO and squashes any in-flight fetch.

Parameters:
ADDR_WIDTH, 32, PC / memory address width
DATA_WIDTH, 32, instruction width
FQ_DEPTH, 2, fetch-queue entries (power of two, >=2)
RESET_ADDR, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
redirect_valid  in  1  jump/branch taken this cycle
redirect_pc  in  ADDR_WIDTH  jump target; bits [1:0] ignored, treated as 0
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_WIDTH  fetch address (word aligned)
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid
imem_rdata  in  DATA_WIDTH  response instruction
if_valid  out  1  FIFO head valid to decode
if_ready  in  1  decode accepts head
if_pc  out  ADDR_WIDTH  PC of head instruction
if_instr  out  DATA_WIDTH  head instruction

Behaviour:
- Reset, sampled on clk while rst_n=0:
  - pc_q=RESET_ADDR, FSM=IDLE, FIFO count=0, discard cleared.
  - Outputs: imem_req=0, if_valid=0. imem_addr, if_pc and if_instr are don't-care while their valid is 0; drive 0.
  - A reset asserted mid-fetch abandons the fetch. Any imem_rvalid during or after reset, before a new grant, is ignored.
- FSM states:
  - IDLE: no fetch outstanding.
  - WAIT: fetch outstanding, response will be kept.
  - DISCARD: fetch outstanding, response will be dropped.
- imem_req=1 only when all hold: state==IDLE, (count + 0) < FQ_DEPTH, redirect_valid=0. imem_addr=pc_q.
  - Request is combinational from registered state.
  - Request may be withdrawn without a grant only because of redirect.
- Grant (imem_req & imem_gnt):
  - inflight_pc <= pc_q; pc_q <= pc_q+4, wrapping modulo 2^ADDR_WIDTH.
  - IDLE->WAIT.
- Slot reservation: issue requires count < FQ_DEPTH at issue, and a slot stays reserved until the response arrives. While in WAIT, pops may free slots but no new request issues. Therefore a push never hits a full FIFO.
- Response in WAIT (imem_rvalid): push {inflight_pc, imem_rdata}; WAIT->IDLE.
- Response in DISCARD: drop; DISCARD->IDLE.
- imem_rvalid in IDLE is a protocol error: ignore it, no push.
- Redirect (redirect_valid=1), highest priority:
  - pc_q <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}.
  - FIFO flushed (count=0, pointers reset); if_valid=0 next cycle.
  - Any pop and any response-push that cycle are cancelled.
  - WAIT without imem_rvalid -> DISCARD. WAIT with imem_rvalid -> IDLE, data dropped.
  - DISCARD stays DISCARD unless imem_rvalid arrives -> IDLE.
  - IDLE stays IDLE and no request is issued that cycle.
  - Fetch from the target starts the next cycle at the earliest.
- FIFO:
  - Registered push: data pushed at edge N is visible with if_valid=1 from cycle N+1.
  - Pop on if_valid & if_ready. if_pc/if_instr are stable while if_valid=1 and if_ready=0.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo FQ_DEPTH.
- Latency: with gnt in cycle 0 and rvalid in cycle 1, if_valid=1 in cycle 2. The next request is issued in cycle 2.
- Throughput: one instruction per 2 cycles when memory has 1-cycle response and gnt is immediate.

Test Plan:
- Reset then release, gnt=1, rvalid one cycle after each grant, if_ready=1 -> imem_addr sequence 0x0,0x4,0x8. if_pc/if_instr match in order. No request in the first cycle with rst_n=0.
- if_ready=0, FQ_DEPTH=2 -> exactly two fetches (0x0,0x4), then imem_req stays 0. Raising if_ready pops 0x0, then a fetch of 0x8 issues.
- Redirect to 0x1003 while WAIT on 0x4 (response arrives 2 cycles later) -> response for 0x4 dropped, FIFO empty. Next imem_addr=0x1000, and 0x1000 is the first if_pc delivered.
- Redirect in the same cycle as imem_rvalid with if_valid=1 and if_ready=1 -> no push, no pop. FIFO empty next cycle, FSM IDLE, next request at the target.
- imem_gnt held 0 for 3 cycles -> imem_req=1 with imem_addr stable at 0x8. pc_q advances only on gnt.
- pc_q=0xFFFF_FFFC, fetch granted -> next imem_addr=0x0000_0000 (wrap). rst_n=0 while WAIT, then stray rvalid -> no push, if_valid=0.
